// File: rtl/exec_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : exec_unit_mc (with common_pkg)
// Brief    : Multi-cycle execution unit. Single-cycle ALU ops, a pipelined
//            signed multiplier and an iterative radix-2 restoring divider,
//            holding one operation at a time behind a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================

package common_pkg;
  typedef enum logic [4:0] {
    ALU_AND                = 5'd0,
    ALU_OR                 = 5'd1,
    ALU_XOR                = 5'd2,
    ALU_ADD                = 5'd3,
    ALU_SUB                = 5'd4,
    ALU_SHIFT_LEFT         = 5'd5,
    ALU_SHIFT_RIGHT        = 5'd6,
    ALU_SHIFT_RIGHT_AR     = 5'd7,
    ALU_SHIFT_RIGHT_AR_IMM = 5'd8,
    ALU_LESS_THAN_SIGNED   = 5'd9,
    ALU_LESS_THAN_UNSIGNED = 5'd10,
    ALU_EQUAL              = 5'd11,
    ALU_MUL                = 5'd12,
    ALU_MULH               = 5'd13,
    ALU_DIV                = 5'd14,
    ALU_DIVU               = 5'd15,
    ALU_REM                = 5'd16,
    ALU_REMU               = 5'd17
  } alu_op_t;
endpackage

module exec_unit_mc
  import common_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int MUL_LAT       = 6,
  parameter int DIV_FAST_ZERO = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  alu_op_t         alu_op,
  input  logic [XLEN-1:0] left_operand,
  input  logic [XLEN-1:0] right_operand,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_res,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam int MVW = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic              accept, mul_fin, div_fin;
  logic              is_mul_op, is_div_op;
  logic [XLEN-1:0]   single_res, mul_res, div_res;
  logic [SHW-1:0]    shamt;

  logic [XLEN-1:0]   mul_a, mul_b, mul_x, mul_y;
  logic              mulh_q, mul_hi_sel;
  logic [MVW-1:0]    mul_vld, mul_vld_shift, mul_vld_load;
  logic [2*XLEN-1:0] mul_x_ext, mul_y_ext, product;

  logic [XLEN-1:0]   quo, rem, dvs, dividend_q, abs_left, abs_right;
  logic [XLEN:0]     rem_shift, rem_diff;
  logic [CW-1:0]     div_cnt;
  logic              neg_q, neg_r, div_zero, rem_sel;
  logic              div_signed_in, left_neg, right_neg;

  assign is_mul_op = (alu_op == ALU_MUL) || (alu_op == ALU_MULH);
  assign is_div_op = (alu_op == ALU_DIV) || (alu_op == ALU_DIVU) ||
                     (alu_op == ALU_REM) || (alu_op == ALU_REMU);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, handshake and completion strobes; flush overrides everything but rst
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mul_fin    = 1'b0;
    div_fin    = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      MUL: begin
        if (mul_vld[MVW-1]) begin
          mul_fin    = 1'b1;
          state_next = DONE;
        end
      end
      DIV: begin
        if ((div_cnt == '0) || ((DIV_FAST_ZERO == 1) && div_zero)) begin
          div_fin    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        in_ready = out_ready;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (rst || flush) in_ready = 1'b0;
    accept = in_valid && in_ready;
    if (accept) begin
      if (is_mul_op)      state_next = (MUL_LAT == 1) ? DONE : MUL;
      else if (is_div_op) state_next = DIV;
      else                state_next = DONE;
    end
    if (flush) state_next = IDLE;
  end

  // Single-cycle ALU; unlisted op codes fall through to ADD
  always_comb begin
    shamt = right_operand[SHW-1:0];
    case (alu_op)
      ALU_AND:                single_res = left_operand & right_operand;
      ALU_OR:                 single_res = left_operand | right_operand;
      ALU_XOR:                single_res = left_operand ^ right_operand;
      ALU_SUB:                single_res = left_operand - right_operand;
      ALU_SHIFT_LEFT:         single_res = left_operand << shamt;
      ALU_SHIFT_RIGHT:        single_res = left_operand >> shamt;
      ALU_SHIFT_RIGHT_AR,
      ALU_SHIFT_RIGHT_AR_IMM: single_res = $signed(left_operand) >>> shamt;
      ALU_LESS_THAN_SIGNED:   single_res = {{(XLEN-1){1'b0}},
                                            ($signed(left_operand) < $signed(right_operand))};
      ALU_LESS_THAN_UNSIGNED: single_res = {{(XLEN-1){1'b0}}, (left_operand < right_operand)};
      ALU_EQUAL:              single_res = {{(XLEN-1){1'b0}}, (left_operand == right_operand)};
      default:                single_res = left_operand + right_operand;
    endcase
  end

  // Multiplier: with MUL_LAT=1 the product comes straight from the ports
  assign mul_x      = (MUL_LAT == 1) ? left_operand : mul_a;
  assign mul_y      = (MUL_LAT == 1) ? right_operand : mul_b;
  assign mul_hi_sel = (MUL_LAT == 1) ? (alu_op == ALU_MULH) : mulh_q;
  assign mul_x_ext  = {{XLEN{mul_x[XLEN-1]}}, mul_x};
  assign mul_y_ext  = {{XLEN{mul_y[XLEN-1]}}, mul_y};
  assign product    = mul_x_ext * mul_y_ext;
  assign mul_res    = mul_hi_sel ? product[2*XLEN-1:XLEN] : product[XLEN-1:0];

  generate
    if (MVW > 1) begin : g_mul_vld_shift
      assign mul_vld_shift = {mul_vld[MVW-2:0], 1'b0};
    end else begin : g_mul_vld_single
      assign mul_vld_shift = '0;
    end
  endgenerate

  // Divider setup (sign/abs), one restoring step and final sign fixup
  always_comb begin
    mul_vld_load    = '0;
    mul_vld_load[0] = is_mul_op;
    div_signed_in   = (alu_op == ALU_DIV) || (alu_op == ALU_REM);
    left_neg        = div_signed_in && left_operand[XLEN-1];
    right_neg       = div_signed_in && right_operand[XLEN-1];
    abs_left        = left_neg ? -left_operand : left_operand;
    abs_right       = right_neg ? -right_operand : right_operand;
    rem_shift       = {rem, quo[XLEN-1]};
    rem_diff        = rem_shift - {1'b0, dvs};
    if (div_zero)     div_res = rem_sel ? dividend_q : '1;
    else if (rem_sel) div_res = neg_r ? -rem : rem;
    else              div_res = neg_q ? -quo : quo;
  end

  // Operand and divider working registers, fully reloaded on every acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      mul_a      <= left_operand;
      mul_b      <= right_operand;
      mulh_q     <= (alu_op == ALU_MULH);
      quo        <= abs_left;
      rem        <= '0;
      dvs        <= abs_right;
      neg_q      <= left_neg ^ right_neg;
      neg_r      <= left_neg;
      div_zero   <= (right_operand == '0);
      dividend_q <= left_operand;
      rem_sel    <= (alu_op == ALU_REM) || (alu_op == ALU_REMU);
    end else if ((state == DIV) && (div_cnt != '0)) begin
      quo <= {quo[XLEN-2:0], ~rem_diff[XLEN]};
      rem <= rem_diff[XLEN] ? rem_shift[XLEN-1:0] : rem_diff[XLEN-1:0];
    end
  end

  // Result register, divide counter and multiply valid pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_res <= '0;
      div_cnt <= '0;
      mul_vld <= '0;
    end else begin
      mul_vld <= flush ? '0 : mul_vld_shift;
      if (accept) begin
        mul_vld <= mul_vld_load;
        div_cnt <= CW'(XLEN);
        if (is_mul_op && (MUL_LAT == 1)) alu_res <= mul_res;
        else if (!is_mul_op && !is_div_op) alu_res <= single_res;
      end else if ((state == DIV) && (div_cnt != '0)) begin
        div_cnt <= div_cnt - CW'(1);
      end
      if (mul_fin) alu_res <= mul_res;
      if (div_fin) alu_res <= div_res;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_unit_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_unit_mc
// Brief    : Self-checking bench for exec_unit_mc (XLEN=32, MUL_LAT=6,
//            DIV_FAST_ZERO=1): transaction-level latency model plus directed
//            vectors with literal expected results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_unit_mc;
  import common_pkg::*;

  localparam int XLEN = 32;
  localparam int MLAT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  alu_op_t     alu_op = ALU_ADD;
  logic [31:0] left_operand = '0;
  logic [31:0] right_operand = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] alu_res;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  bit cmp_en = 1'b0;

  // model state
  bit          m_inflight = 1'b0;
  bit          m_valid = 1'b0;
  int          m_remain = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  bit          m_ready;
  bit          m_rdy_edge;
  int          m_lat;

  exec_unit_mc #(.XLEN(XLEN), .MUL_LAT(MLAT), .DIV_FAST_ZERO(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .left_operand(left_operand), .right_operand(right_operand),
    .out_valid(out_valid), .out_ready(out_ready), .alu_res(alu_res), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_result(input alu_op_t op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint p;
    case (op)
      ALU_AND:                return a & b;
      ALU_OR:                 return a | b;
      ALU_XOR:                return a ^ b;
      ALU_SUB:                return a - b;
      ALU_SHIFT_LEFT:         return a << b[4:0];
      ALU_SHIFT_RIGHT:        return a >> b[4:0];
      ALU_SHIFT_RIGHT_AR,
      ALU_SHIFT_RIGHT_AR_IMM: return $signed(a) >>> b[4:0];
      ALU_LESS_THAN_SIGNED:   return (sa < sb) ? 32'd1 : 32'd0;
      ALU_LESS_THAN_UNSIGNED: return (a < b) ? 32'd1 : 32'd0;
      ALU_EQUAL:              return (a == b) ? 32'd1 : 32'd0;
      ALU_MUL:  begin p = sa * sb; return p[31:0];  end
      ALU_MULH: begin p = sa * sb; return p[63:32]; end
      ALU_DIV:  begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      ALU_REM:  begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
      ALU_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      ALU_REMU: return (b == 0) ? a : a % b;
      default:  return a + b;
    endcase
  endfunction

  function automatic int ref_latency(input alu_op_t op, input logic [31:0] b);
    case (op)
      ALU_MUL, ALU_MULH: return MLAT;
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: return (b == 0) ? 2 : XLEN + 2;
      default: return 1;
    endcase
  endfunction

  // Transaction model: one op in flight, delivered after its latency, held until taken
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_inflight = 1'b0; m_valid = 1'b0; m_res = '0;
    end else if (flush) begin
      m_inflight = 1'b0; m_valid = 1'b0;
    end else begin
      m_rdy_edge = !m_inflight && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 1'b0;
      if (m_inflight) begin
        m_remain--;
        if (m_remain == 0) begin
          m_inflight = 1'b0; m_valid = 1'b1; m_res = m_pend;
        end
      end
      if (in_valid && m_rdy_edge) begin
        m_lat = ref_latency(alu_op, right_operand);
        if (m_lat == 1) begin
          m_valid = 1'b1; m_res = ref_result(alu_op, left_operand, right_operand);
        end else begin
          m_inflight = 1'b1; m_remain = m_lat - 1;
          m_pend = ref_result(alu_op, left_operand, right_operand);
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      m_ready = !rst && !flush && !m_inflight && (!m_valid || out_ready);
      chk("model out_valid", out_valid, m_valid);
      chk("model in_ready", in_ready, m_ready);
      chk("model busy", busy, m_inflight || m_valid);
      if (m_valid) chk("model alu_res", alu_res, m_res);
    end
  end

  task automatic wait_accept(input string name, output int acc_c);
    bit got = 1'b0;
    acc_c = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; acc_c = cyc; break; end
    end
    if (!got) chk({name, " accept timeout"}, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string name, input alu_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int acc_c;
    bit got = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; alu_op = op; left_operand = a; right_operand = b;
    wait_accept(name, acc_c);
    if (out_valid) got = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    if (!got) chk({name, " result timeout"}, 0, 1);
    else begin
      chk({name, " res"}, alu_res, exp);
      chk({name, " latency"}, cyc - acc_c, exp_lat);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int acc_c;
    int seen;
    // reset
    @(posedge clk); #1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset alu_res", alu_res, 32'h0);
    chk("reset in_ready", in_ready, 1'b0);
    chk("reset busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", in_ready, 1'b1);

    // back-to-back ADD then SUB
    @(posedge clk); #1;
    in_valid = 1'b1; alu_op = ALU_ADD; left_operand = 32'h7FFF_FFFF; right_operand = 32'd1;
    @(negedge clk);
    chk("b2b add ready", in_ready, 1'b1);
    @(posedge clk); #1;
    alu_op = ALU_SUB; left_operand = 32'd5; right_operand = 32'd7;
    @(negedge clk);
    chk("b2b add valid", out_valid, 1'b1);
    chk("b2b add res", alu_res, 32'h8000_0000);
    chk("b2b sub ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b sub valid", out_valid, 1'b1);
    chk("b2b sub res", alu_res, 32'hFFFF_FFFE);
    @(posedge clk); #1;

    // single-cycle ops
    run_op("and",  ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
    run_op("or",   ALU_OR,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1);
    run_op("xor",  ALU_XOR, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1);
    run_op("sll",  ALU_SHIFT_LEFT, 32'h1, 32'h21, 32'h2, 1);
    run_op("srl",  ALU_SHIFT_RIGHT, 32'h8000_0000, 32'h4, 32'h0800_0000, 1);
    run_op("sraimm", ALU_SHIFT_RIGHT_AR_IMM, 32'h8000_0010, 32'h4, 32'hF800_0001, 1);
    run_op("slt",  ALU_LESS_THAN_SIGNED, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
    run_op("sltu", ALU_LESS_THAN_UNSIGNED, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
    run_op("eq",   ALU_EQUAL, 32'h1234, 32'h1234, 32'h1, 1);
    run_op("unk",  alu_op_t'(5'd25), 32'd3, 32'd4, 32'd7, 1);

    // multiply
    run_op("mulh ff", ALU_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 6);
    run_op("mul ff",  ALU_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 6);
    run_op("mul",     ALU_MUL,  32'h1234_5678, 32'h10, 32'h2345_6780, 6);
    run_op("mulh neg", ALU_MULH, 32'h8000_0000, 32'h2, 32'hFFFF_FFFF, 6);

    // divide
    run_op("div ovf",  ALU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
    run_op("rem ovf",  ALU_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 34);
    run_op("divu",     ALU_DIVU, 32'd100, 32'd7, 32'd14, 34);
    run_op("remu",     ALU_REMU, 32'd100, 32'd7, 32'd2, 34);
    run_op("div neg",  ALU_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_op("rem neg",  ALU_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_op("divu z",   ALU_DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, 2);
    run_op("rem z",    ALU_REM,  32'hFFFF_FFF7, 32'h0, 32'hFFFF_FFF7, 2);
    run_op("div z",    ALU_DIV,  32'd5, 32'h0, 32'hFFFF_FFFF, 2);

    // backpressure
    out_ready = 1'b0;
    in_valid = 1'b1; alu_op = ALU_SHIFT_RIGHT_AR; left_operand = 32'h8000_0000; right_operand = 32'h24;
    wait_accept("bp", acc_c);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp valid", out_valid, 1'b1);
      chk("bp res", alu_res, 32'hF800_0000);
      chk("bp in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp release ready", in_ready, 1'b1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp drained", out_valid, 1'b0);
    @(posedge clk); #1;

    // flush on divide cycle 10, with an op offered in the flush cycle
    in_valid = 1'b1; alu_op = ALU_DIVU; left_operand = 32'd1000; right_operand = 32'd3;
    wait_accept("flush div", acc_c);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; in_valid = 1'b1; alu_op = ALU_ADD; left_operand = 32'd1; right_operand = 32'd1;
    @(negedge clk);
    chk("flush in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush busy", busy, 1'b0);
    chk("flush ready", in_ready, 1'b1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("flush no result", seen, 0);
    @(posedge clk); #1;

    // reset on multiply cycle 3
    in_valid = 1'b1; alu_op = ALU_MUL; left_operand = 32'd9; right_operand = 32'd9;
    wait_accept("rst mul", acc_c);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst ready", in_ready, 1'b1);
    chk("rst alu_res", alu_res, 32'h0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst no result", seen, 0);

    // one more op after the abort to confirm clean restart
    @(posedge clk); #1;
    run_op("post rst mul", ALU_MUL, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 6);

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always terminates
  initial begin
    #200000;
    fails++;
    $display("FAIL global timeout: got cycle %0d expected completion", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exec_unit_mc.md
EXEC_UNIT_MC -- requirements
Module: exec_unit_mc

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 8, 16, 32, 64.
REQ-002 Parameter MUL_LAT, default 6, multiply latency in cycles from acceptance to out_valid; legal range 1..8.
REQ-003 Parameter DIV_FAST_ZERO, default 1; when 1, divide/remainder by zero completes in 2 cycles instead of the full iteration count.
REQ-004 Port clk  input  1  clock; all state changes on the rising edge.
REQ-005 Port rst  input  1  reset, synchronous, active-high.
REQ-006 Port flush  input  1  synchronous kill of the in-flight operation.
REQ-007 Port in_valid  input  1  operation offered.
REQ-008 Port in_ready  output  1  unit accepts the operation this cycle.
REQ-009 Port alu_op  input  alu_op_t  operation code from common_pkg.
REQ-010 Port left_operand  input  XLEN  first operand.
REQ-011 Port right_operand  input  XLEN  second operand.
REQ-012 Port out_valid  output  1  alu_res is valid.
REQ-013 Port out_ready  input  1  consumer takes the result.
REQ-014 Port alu_res  output  XLEN  registered result.
REQ-015 Port busy  output  1  high in every state other than IDLE; the pipeline uses busy to stall upstream.

Function
REQ-016 The unit SHALL hold at most one operation; it is accepted on a cycle with in_valid && in_ready.
REQ-017 FSM states SHALL be IDLE, MUL, DIV, DONE, with these transitions:
- IDLE -> DONE on a single-cycle op.
- IDLE -> MUL on MUL/MULH.
- IDLE -> DIV on DIV/DIVU/REM/REMU.
- MUL -> DONE after MUL_LAT-1 cycles.
- DIV -> DONE at divide completion.
- DONE -> IDLE on out_ready with no new acceptance.
REQ-018 in_ready SHALL be 1 in IDLE, 1 in DONE when out_ready=1, and 0 otherwise; in DONE with out_ready && in_valid, the new op is accepted and the FSM branches as from IDLE.
REQ-019 out_valid SHALL equal (state==DONE); alu_res and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-020 Single-cycle ops SHALL produce out_valid exactly 1 cycle after acceptance: AND, OR, XOR, ADD, SUB, SHIFT_LEFT, SHIFT_RIGHT, SHIFT_RIGHT_AR, SHIFT_RIGHT_AR_IMM, LESS_THAN_SIGNED, LESS_THAN_UNSIGNED, EQUAL.
REQ-021 Shift amount SHALL be right_operand[$clog2(XLEN)-1:0] for all shift ops.
REQ-022 Compare/equal results SHALL be zero-extended 1-bit values.
REQ-023 Any op code not listed in REQ-020 or REQ-017 SHALL execute as ADD.
REQ-024 Multiply SHALL be a signed x signed 2*XLEN product.
- MUL returns bits [XLEN-1:0]; MULH returns bits [2*XLEN-1:XLEN].
- Operands are registered at acceptance; the pipeline depth makes out_valid assert exactly MUL_LAT cycles after acceptance.
REQ-025 Divide SHALL be iterative radix-2 restoring, one quotient bit per cycle, taking XLEN+2 cycles from acceptance to out_valid:
- 1 cycle: sign/abs setup.
- XLEN cycles: iterations.
- 1 cycle: sign fixup.
REQ-026 Signed divide/remainder SHALL follow the RISC-V rules:
- The quotient is negated when operand signs differ.
- The remainder takes the dividend's sign.
REQ-027 Divide by zero SHALL return quotient all-ones (DIV and DIVU) and remainder equal to the dividend; with DIV_FAST_ZERO=1, out_valid asserts 2 cycles after acceptance.
REQ-028 Signed overflow (dividend = most-negative value, divisor = -1) SHALL return quotient = most-negative value and remainder 0, in the full XLEN+2 cycles.
REQ-029 flush SHALL force the FSM to IDLE and out_valid to 0 on the next edge, discarding any in-flight or undelivered result.
- An operation offered in the same cycle as flush SHALL NOT be accepted.
- in_ready SHALL be 0 while flush=1.
REQ-030 A new acceptance SHALL reload all operand, counter and pipeline state, so no stale intermediate value leaks into a later result.

Reset
REQ-031 On rst=1, the state SHALL go to IDLE, and out_valid, busy, alu_res, the divide counter and all multiply pipeline valid bits SHALL go to 0.
REQ-032 rst SHALL take priority over flush and over any handshake in the same cycle.
REQ-033 rst asserted mid-multiply or mid-divide SHALL abort the operation, and no out_valid SHALL follow after rst deasserts.
REQ-034 in_ready SHALL be 0 during rst and 1 on the first cycle after rst deasserts.

Verification
REQ-035 XLEN=32, ADD 0x7FFFFFFF + 1 with out_ready=1, followed back-to-back by SUB 5-7 -> results 0x80000000 then 0xFFFFFFFE on consecutive cycles, each 1 cycle after its acceptance.
REQ-036 MUL_LAT=6, MULH 0xFFFFFFFF x 0xFFFFFFFF -> alu_res 0x00000000 (MUL returns 0x00000001), out_valid exactly 6 cycles after acceptance, in_ready=0 in between.
REQ-037 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 after 34 cycles; REM of the same operands -> 0; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2.
REQ-038 DIV_FAST_ZERO=1, DIVU 0x1234 / 0 -> 0xFFFFFFFF after 2 cycles; REM -9 / 0 -> 0xFFFFFFF7.
REQ-039 Backpressure: hold out_ready=0 for 5 cycles after a SHIFT_RIGHT_AR of 0x80000000 by 0x24 -> alu_res stays 0xF8000000 with out_valid=1 and in_ready=0 until out_ready rises.
REQ-040 Assert flush on divide cycle 10, and separately rst on multiply cycle 3 -> out_valid never asserts for either op; busy=0 and in_ready=1 on the following cycle.
